// File: rtl/vga_rx.sv
// VGA receive side: samples RGB/syncs, recovers x/y from sync edges, locks onto the timing.
// Optional VGA_RX_MEASURE_EN adds h_meas/v_meas line/frame length measurement outputs.
module vga_rx #(
  parameter int unsigned hva         = 1920,
  parameter int unsigned hfp         = 88,
  parameter int unsigned hsp         = 44,
  parameter int unsigned hbp         = 148,
  parameter int unsigned vva         = 1080,
  parameter int unsigned vfp         = 4,
  parameter int unsigned vsp         = 5,
  parameter int unsigned vbp         = 36,
  parameter int unsigned hpp         = 1,
  parameter int unsigned vpp         = 1,
  parameter int unsigned rd          = 5,
  parameter int unsigned gd          = 6,
  parameter int unsigned bd          = 5,
  parameter int unsigned cw          = 12,
  parameter int unsigned lock_frames = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [rd-1:0]       R,
  input  logic [gd-1:0]       G,
  input  logic [bd-1:0]       B,
  input  logic                HSync,
  input  logic                VSync,
  output logic [rd+gd+bd-1:0] data,
  output logic                valid,
  output logic                sol,
  output logic                sof,
  output logic [cw-1:0]       x,
  output logic [cw-1:0]       y,
  output logic                locked,
`ifdef VGA_RX_MEASURE_EN
  output logic [cw-1:0]       h_meas,
  output logic [cw-1:0]       v_meas,
`endif
  output logic                err
);

  localparam int unsigned HTOT = hva + hfp + hsp + hbp;
  localparam int unsigned VTOT = vva + vfp + vsp + vbp;
  localparam int unsigned H0   = hsp + hbp;
  localparam int unsigned H1   = hsp + hbp + hva - 1;
  localparam int unsigned V0   = vsp + vbp;
  localparam int unsigned V1   = vsp + vbp + vva - 1;
  localparam int unsigned DW   = rd + gd + bd;
  localparam int unsigned LW   = cw + 1;
  localparam int unsigned GW   = $clog2(lock_frames + 1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  logic [DW-1:0] pix1, pix2;
  logic          hs_act, vs_act, hs_prev, vs_hle;
  logic [cw-1:0] hc, vc;
  logic          hle, vle;
  logic [LW-1:0] line_len, frame_len;
  logic          line_bad, frame_bad, active, valid_nx;
  state_t        state, state_nx;
  logic [GW-1:0] good, good_nx;
  logic          err_nx;

  // Input capture with sync polarity normalised to active-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix1    <= '0;
      hs_act  <= 1'b0;
      vs_act  <= 1'b0;
      hs_prev <= 1'b0;
    end else begin
      pix1    <= {R, G, B};
      hs_act  <= (HSync == 1'(hpp));
      vs_act  <= (VSync == 1'(vpp));
      hs_prev <= hs_act;
    end
  end

  assign hle       = hs_act & ~hs_prev;
  assign vle       = hle & vs_act & ~vs_hle;
  assign line_len  = {1'b0, hc} + LW'(1);
  assign frame_len = {1'b0, vc} + LW'(1);
  assign line_bad  = hle && (line_len != LW'(HTOT));
  assign frame_bad = vle && (frame_len != LW'(VTOT));

  // Position counters; hc/vc/pix2 all describe the same sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix2   <= '0;
      hc     <= '0;
      vc     <= '0;
      vs_hle <= 1'b0;
    end else begin
      pix2 <= pix1;
      if (hle) begin
        hc     <= '0;
        vs_hle <= vs_act;
        if (vle)
          vc <= '0;
        else if (vc != '1)
          vc <= vc + cw'(1);
      end else if (hc != '1) begin
        hc <= hc + cw'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEARCH;
      good  <= '0;
    end else begin
      state <= state_nx;
      good  <= good_nx;
    end
  end

  // Lock tracking; the line check takes precedence over the frame check
  always_comb begin
    state_nx = state;
    good_nx  = good;
    err_nx   = 1'b0;
    case (state)
      SEARCH: begin
        if (vle) begin
          state_nx = TRACK;
          good_nx  = '0;
        end
      end
      TRACK: begin
        if (line_bad || frame_bad) begin
          state_nx = SEARCH;
          good_nx  = '0;
        end else if (vle) begin
          good_nx = good + GW'(1);
          if (good_nx == GW'(lock_frames))
            state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad) begin
          state_nx = SEARCH;
          good_nx  = '0;
          err_nx   = 1'b1;
        end
      end
      default: begin
        state_nx = SEARCH;
        good_nx  = '0;
      end
    endcase
  end

  assign active   = (hc >= cw'(H0)) && (hc <= cw'(H1)) && (vc >= cw'(V0)) && (vc <= cw'(V1));
  assign valid_nx = (state_nx == LOCKED) && active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data   <= '0;
      valid  <= 1'b0;
      sol    <= 1'b0;
      sof    <= 1'b0;
      x      <= '0;
      y      <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid  <= valid_nx;
      sol    <= valid_nx && (hc == cw'(H0));
      sof    <= valid_nx && (hc == cw'(H0)) && (vc == cw'(V0));
      locked <= (state_nx == LOCKED);
      err    <= err_nx;
      if (valid_nx) begin
        data <= pix2;
        x    <= hc - cw'(H0);
        y    <= vc - cw'(V0);
      end
    end
  end

`ifdef VGA_RX_MEASURE_EN
  // A saturated counter reports all-ones rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_meas <= '0;
      v_meas <= '0;
    end else begin
      if (hle)
        h_meas <= (hc == '1) ? hc : line_len[cw-1:0];
      if (vle)
        v_meas <= (vc == '1) ? vc : frame_len[cw-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_vga_rx.sv
// Directed bench for vga_rx: one positive-sync and one inverted-sync instance on a small mode.
// Covers lock, data/strobes, latency, async reset, line/frame errors and hc saturation.
module tb_vga_rx;

  localparam int HTOT = 25;
  localparam int VTOT = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] r = '0;
  logic [5:0] g = '0;
  logic [4:0] b = '0;
  logic       hs_on = 1'b0;
  logic       vs_on = 1'b0;

  logic [15:0] data_o   [2];
  logic [11:0] x_o      [2];
  logic [11:0] y_o      [2];
  logic        valid_o  [2];
  logic        sol_o    [2];
  logic        sof_o    [2];
  logic        locked_o [2];
  logic        err_o    [2];
`ifdef VGA_RX_MEASURE_EN
  logic [11:0] hm_o [2];
  logic [11:0] vm_o [2];
`endif

  vga_rx #(.hva(16), .hfp(2), .hsp(3), .hbp(4), .vva(8), .vfp(1), .vsp(2), .vbp(3),
           .hpp(1), .vpp(1), .rd(5), .gd(6), .bd(5), .cw(12), .lock_frames(2)) dut_p (
    .clk(clk), .rst(rst), .R(r), .G(g), .B(b), .HSync(hs_on), .VSync(vs_on),
    .data(data_o[0]), .valid(valid_o[0]), .sol(sol_o[0]), .sof(sof_o[0]),
    .x(x_o[0]), .y(y_o[0]), .locked(locked_o[0]),
`ifdef VGA_RX_MEASURE_EN
    .h_meas(hm_o[0]), .v_meas(vm_o[0]),
`endif
    .err(err_o[0])
  );

  vga_rx #(.hva(16), .hfp(2), .hsp(3), .hbp(4), .vva(8), .vfp(1), .vsp(2), .vbp(3),
           .hpp(0), .vpp(0), .rd(5), .gd(6), .bd(5), .cw(12), .lock_frames(2)) dut_n (
    .clk(clk), .rst(rst), .R(r), .G(g), .B(b), .HSync(~hs_on), .VSync(~vs_on),
    .data(data_o[1]), .valid(valid_o[1]), .sol(sol_o[1]), .sof(sof_o[1]),
    .x(x_o[1]), .y(y_o[1]), .locked(locked_o[1]),
`ifdef VGA_RX_MEASURE_EN
    .h_meas(hm_o[1]), .v_meas(vm_o[1]),
`endif
    .err(err_o[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: event counters plus an independent raster-order model of expected pixels
  int   nv[2] = '{0, 0}, nsol[2] = '{0, 0}, nsof[2] = '{0, 0};
  int   nerr_p[2] = '{0, 0}, nerr_hi[2] = '{0, 0}, seq_bad[2] = '{0, 0};
  int   seen_cyc[2] = '{0, 0}, lock_cyc[2] = '{0, 0}, err_cyc[2] = '{0, 0};
  int   ex[2] = '{0, 0}, ey[2] = '{0, 0};
  logic [15:0] seen_data[2] = '{16'd0, 16'd0};
  logic prev_err[2] = '{1'b0, 1'b0}, prev_lock[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (err_o[d]) nerr_hi[d]++;
      if (err_o[d] && !prev_err[d]) begin
        nerr_p[d]++;
        err_cyc[d] = cyc;
      end
      if (locked_o[d] && !prev_lock[d]) lock_cyc[d] = cyc;
      prev_err[d]  = err_o[d];
      prev_lock[d] = locked_o[d];
      if (valid_o[d]) begin
        nv[d]++;
        if (sol_o[d]) nsol[d]++;
        if (sof_o[d]) nsof[d]++;
        if (x_o[d] == 12'd0 && y_o[d] == 12'd0) begin
          ex[d] = 0;
          ey[d] = 0;
        end
        if (x_o[d] != 12'(ex[d]) || y_o[d] != 12'(ey[d]) ||
            data_o[d] != {5'(ex[d]), 6'(ey[d]), 5'd0} ||
            sol_o[d] != (ex[d] == 0) || sof_o[d] != (ex[d] == 0 && ey[d] == 0))
          seq_bad[d]++;
        if (ex[d] == 5 && ey[d] == 3) begin
          seen_cyc[d]  = cyc;
          seen_data[d] = data_o[d];
        end
        ex[d]++;
        if (ex[d] == 16) begin
          ex[d] = 0;
          ey[d] = (ey[d] + 1) % 8;
        end
      end else if (sol_o[d] || sof_o[d]) begin
        seq_bad[d]++;
      end
    end
  end

  int drv_edge = 0, vle_edge = 0, line_edge = 0;

  // One line: sync at clocks 0..2, pixels at 7..22; sync rows 0..1, active rows 5..12
  task automatic send_line(input int len, input int row);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      hs_on = (c < 3);
      vs_on = (row < 2);
      if (c >= 7 && c < 23 && row >= 5 && row < 13) begin
        r = 5'(c - 7);
        g = 6'(row - 5);
      end else begin
        r = '0;
        g = '0;
      end
      b = '0;
      if (c == 0) begin
        line_edge = cyc + 1;
        if (row == 0) vle_edge = cyc + 1;
      end
      if (c == 12 && row == 8) drv_edge = cyc + 1;
    end
  endtask

  task automatic send_frame(input int nlines);
    for (int row = 0; row < nlines; row++) send_line(HTOT, row);
  endtask

  int bv[2], bsol[2], bsof[2], berr_p[2], berr_hi[2], bseq[2];

  task automatic mark();
    for (int d = 0; d < 2; d++) begin
      bv[d] = nv[d]; bsol[d] = nsol[d]; bsof[d] = nsof[d];
      berr_p[d] = nerr_p[d]; berr_hi[d] = nerr_hi[d]; bseq[d] = seq_bad[d];
    end
  endtask

  task automatic check_win(input string tag, input int ev, input int esol, input int esof,
                           input int eerr, input int elock);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.valid[%0d]", tag, d), nv[d] - bv[d], ev);
      chk($sformatf("%s.sol[%0d]", tag, d), nsol[d] - bsol[d], esol);
      chk($sformatf("%s.sof[%0d]", tag, d), nsof[d] - bsof[d], esof);
      chk($sformatf("%s.err_pulses[%0d]", tag, d), nerr_p[d] - berr_p[d], eerr);
      chk($sformatf("%s.err_cycles[%0d]", tag, d), nerr_hi[d] - berr_hi[d], eerr);
      chk($sformatf("%s.pixel_seq[%0d]", tag, d), seq_bad[d] - bseq[d], 0);
      chk($sformatf("%s.locked[%0d]", tag, d), locked_o[d], elock);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.valid[%0d]", tag, d), valid_o[d], 0);
      chk($sformatf("%s.sol[%0d]", tag, d), sol_o[d], 0);
      chk($sformatf("%s.sof[%0d]", tag, d), sof_o[d], 0);
      chk($sformatf("%s.locked[%0d]", tag, d), locked_o[d], 0);
      chk($sformatf("%s.err[%0d]", tag, d), err_o[d], 0);
      chk($sformatf("%s.data[%0d]", tag, d), data_o[d], 0);
      chk($sformatf("%s.x[%0d]", tag, d), x_o[d], 0);
      chk($sformatf("%s.y[%0d]", tag, d), y_o[d], 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Clean frames: lock one cycle after the third VSync leading edge
    mark(); send_frame(VTOT); send_frame(VTOT);
    check_win("pre_lock", 0, 0, 0, 0, 0);
    mark(); send_frame(VTOT);
    check_win("lock_f3", 128, 8, 1, 0, 1);
    for (int d = 0; d < 2; d++) chk($sformatf("lock_edge[%0d]", d), lock_cyc[d] - vle_edge, 1);
    mark(); send_frame(VTOT);
    check_win("frame4", 128, 8, 1, 0, 1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("latency[%0d]", d), seen_cyc[d] - drv_edge, 2);
      chk($sformatf("pix_5_3[%0d]", d), seen_data[d], 16'h2860);
    end
`ifdef VGA_RX_MEASURE_EN
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("h_meas_clean[%0d]", d), hm_o[d], 25);
      chk($sformatf("v_meas_clean[%0d]", d), vm_o[d], 14);
    end
`endif

    // Asynchronous reset mid-frame, then relock from scratch
    for (int row = 0; row < 7; row++) send_line(HTOT, row);
    #1 rst = 1'b1;
    #1 chk_zero("rst_async");
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    mark(); send_frame(VTOT); send_frame(VTOT);
    check_win("rst_pre", 0, 0, 0, 0, 0);
    mark(); send_frame(VTOT);
    check_win("rst_relock", 128, 8, 1, 0, 1);

    // Short line (24 clocks) in row 8: error at the next line start
    mark();
    for (int row = 0; row < 10; row++) send_line((row == 8) ? 24 : HTOT, row);
    for (int d = 0; d < 2; d++) chk($sformatf("line_err_edge[%0d]", d), err_cyc[d] - line_edge, 1);
`ifdef VGA_RX_MEASURE_EN
    for (int d = 0; d < 2; d++) chk($sformatf("h_meas_short[%0d]", d), hm_o[d], 24);
`endif
    for (int row = 10; row < VTOT; row++) send_line(HTOT, row);
    check_win("line_err", 64, 4, 1, 1, 0);
    mark(); send_frame(VTOT); send_frame(VTOT);
    check_win("line_wait", 0, 0, 0, 0, 0);
    mark(); send_frame(VTOT);
    check_win("line_relock", 128, 8, 1, 0, 1);

    // 15-line frame: error at the following VSync edge, then a 14-line frame counts in TRACK
    mark(); send_frame(VTOT + 1);
    check_win("long_frame", 128, 8, 1, 0, 1);
    mark(); send_frame(VTOT);
    check_win("frame_err", 0, 0, 0, 1, 0);
`ifdef VGA_RX_MEASURE_EN
    for (int d = 0; d < 2; d++) chk($sformatf("v_meas_long[%0d]", d), vm_o[d], 15);
`endif
    mark(); send_frame(VTOT); send_frame(VTOT);
    check_win("frame_track", 0, 0, 0, 0, 0);
    mark(); send_frame(VTOT);
    check_win("frame_relock", 128, 8, 1, 0, 1);

    // HSync held inactive: hc saturates, error only at the next line start
    mark();
    repeat (5000) @(negedge clk);
    check_win("hold", 0, 0, 0, 0, 1);
    chk("hc_sat[0]", dut_p.hc, 4095);
    chk("hc_sat[1]", dut_n.hc, 4095);
    mark(); send_frame(VTOT);
    check_win("sat_err", 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
